// File: rtl/mem_pkg.sv
// Shared definitions for the byte-stream memory loader: header length,
// frame state encoding and the word-count width.
package mem_pkg;

  localparam int HDR_BYTES = 4;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    HDR,
    DATA,
    DONE
  } state_t;

endpackage

// File: rtl/byte_to_word.sv
// Shift-in word assembler: collects DATA_W/8 bytes LSB-first and presents the
// completed word combinationally together with the strobe on the last byte.
module byte_to_word #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [7:0]        in_data,
  input  logic              take,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [IDX_W-1:0] idx;
  logic             last;

  assign last       = (idx == IDX_W'(BYTES - 1));
  assign word_valid = take && last;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      idx <= '0;
    end else if (take) begin
      idx <= last ? '0 : idx + 1'b1;
    end
  end

  generate
    if (BYTES == 1) begin : g_single
      assign word = in_data;
    end else begin : g_multi
      logic [DATA_W-1:0] acc;

      // NOTE: the shift register carries no reset; clearing the byte index
      // is enough to discard a partial word because stale bytes are always
      // shifted out before the next word completes.
      always_ff @(posedge clk) begin
        if (take) begin
          acc <= {in_data, acc[DATA_W-1:8]};
        end
      end

      // The final byte bypasses the register so the word is ready on its edge.
      assign word = {in_data, acc[DATA_W-1:8]};
    end
  endgenerate

endmodule

// File: rtl/mem_loader.sv
// Framed byte-stream memory writer: parses a 4-byte little-endian header
// (start address, word count) and writes the assembled payload words to RAM.
module mem_loader
  import mem_pkg::*;
#(
  parameter int WORD_N = 256,
  parameter int ADDR_W = $clog2(WORD_N),
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wr,
  output logic              busy,
  output logic              done
);

  state_t            state, state_next;
  logic [1:0]        hdr_idx;
  logic [7:0]        lo_byte;
  logic [15:0]       hdr_val;
  logic [ADDR_W-1:0] addr, addr_next;
  logic [CNT_W-1:0]  count;
  logic              accept, hdr_take, data_take, hdr_last;
  logic [DATA_W-1:0] word;
  logic              word_valid;

  // An abort in the same cycle as a byte drops the byte.
  assign accept    = in_valid && in_ready && !abort;
  assign hdr_take  = accept && (state == HDR);
  assign data_take = accept && (state == DATA);
  assign hdr_last  = (hdr_idx == 2'(HDR_BYTES - 1));
  assign hdr_val   = {in_data, lo_byte};
  assign addr_next = (addr == ADDR_W'(WORD_N - 1)) ? '0 : addr + 1'b1;

  byte_to_word #(
    .DATA_W(DATA_W)
  ) u_assembler (
    .clk       (clk),
    .clear     (rst || abort),
    .in_data   (in_data),
    .take      (data_take),
    .word      (word),
    .word_valid(word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state <= HDR;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      HDR:     if (hdr_take && hdr_last) state_next = (hdr_val != '0) ? DATA : DONE;
      DATA:    if (word_valid && count == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = HDR;
      default: state_next = HDR;
    endcase
  end

  // in_ready drops combinationally with rst so no byte is taken while in reset.
  always_comb begin
    in_ready = !rst && (state != DONE);
    busy     = (state != HDR) || (hdr_idx != 2'd0);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr   <= '0;
      wdata   <= '0;
      wr      <= 1'b0;
      hdr_idx <= 2'd0;
      lo_byte <= 8'd0;
      addr    <= '0;
      count   <= '0;
    end else if (abort) begin
      wr      <= 1'b0;
      hdr_idx <= 2'd0;
    end else begin
      wr <= 1'b0;
      if (hdr_take) begin
        hdr_idx <= hdr_last ? 2'd0 : hdr_idx + 2'd1;
        case (hdr_idx)
          2'd0, 2'd2: lo_byte <= in_data;
          2'd1:       addr    <= hdr_val[ADDR_W-1:0];
          default:    count   <= hdr_val;
        endcase
      end
      if (word_valid) begin
        wr    <= 1'b1;
        waddr <= addr;
        wdata <= word;
        addr  <= addr_next;
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader: single word, wrapping burst,
// zero count, stalled stream, abort mid-word and reset mid-header.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst, in_valid, abort;
  logic [7:0]  in_data;
  logic        in_ready, wr, busy, done;
  logic [7:0]  waddr;
  logic [15:0] wdata;

  mem_loader dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .abort   (abort),
    .waddr   (waddr),
    .wdata   (wdata),
    .wr      (wr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [7:0]  a;
    logic [15:0] d;
  } wr_ev_t;

  wr_ev_t wr_q[$];
  wr_ev_t exp_q[$];
  int     done_q[$];
  wr_ev_t mon_ev;

  // Observed write and done events, time-stamped in edge numbers.
  always @(negedge clk) begin
    if (wr) begin
      mon_ev.c = cyc;
      mon_ev.a = waddr;
      mon_ev.d = wdata;
      wr_q.push_back(mon_ev);
    end
    if (done) done_q.push_back(cyc);
  end

  int n_pass  = 0;
  int n_total = 0;
  int last_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waits;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    waits = 0;
    while (!in_ready && waits < 10) begin
      @(negedge clk);
      #1;
      waits++;
    end
    check("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic send_header(input logic [15:0] a, input logic [15:0] n);
    send_byte(a[7:0], 0);
    send_byte(a[15:8], 0);
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask

  task automatic send_word(input logic [15:0] w, input logic [7:0] a, input int g_lo, input int g_hi);
    wr_ev_t ev;
    send_byte(w[7:0], g_lo);
    send_byte(w[15:8], g_hi);
    ev.c = last_acc;
    ev.a = a;
    ev.d = w;
    exp_q.push_back(ev);
  endtask

  task automatic finish_frame(input string tag, input int n_done, input int done_cyc);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_waddr%0d", tag, i), wr_q[i].a, exp_q[i].a);
      check($sformatf("%s_wdata%0d", tag, i), wr_q[i].d, exp_q[i].d);
      check($sformatf("%s_wr_cycle%0d", tag, i), wr_q[i].c, exp_q[i].c);
    end
    check({tag, "_done_count"}, done_q.size(), n_done);
    if (n_done > 0 && done_q.size() > 0) check({tag, "_done_cycle"}, done_q[0], done_cyc);
    wr_q.delete();
    exp_q.delete();
    done_q.delete();
  endtask

  // Frame 10 00 01 00 34 12 (or any one-word frame) with cycle-exact checks.
  task automatic single_word(input string tag, input logic [7:0] a, input logic [15:0] w);
    check({tag, "_busy_idle"}, busy, 0);
    send_byte(a, 0);
    check({tag, "_busy_first"}, busy, 1);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(w, a, 0, 0);
    in_valid = 1'b0;
    check({tag, "_wr_at_end"}, wr, 1);
    check({tag, "_done_at_end"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 1);
    check({tag, "_ready_at_done"}, in_ready, 0);
    @(posedge clk);
    #1;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_ready_after"}, in_ready, 1);
    check({tag, "_done_after"}, done, 0);
    finish_frame(tag, 1, exp_q[0].c);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dcyc;
    rst      = 1'b1;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wr", wr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    wr_q.delete();
    done_q.delete();

    single_word("single", 8'h10, 16'h1234);

    send_header(16'h00FE, 16'd3);
    send_word(16'hAAAA, 8'hFE, 0, 0);
    send_word(16'hBBBB, 8'hFF, 0, 0);
    send_word(16'hCCCC, 8'h00, 0, 0);
    finish_frame("wrap", 1, last_acc);

    send_header(16'h0005, 16'd0);
    in_valid = 1'b0;
    dcyc = last_acc;
    check("zero_done", done, 1);
    check("zero_ready_low", in_ready, 0);
    check("zero_no_wr", wr, 0);
    @(posedge clk);
    #1;
    check("zero_ready_back", in_ready, 1);
    check("zero_done_gone", done, 0);
    check("zero_busy_gone", busy, 0);
    finish_frame("zero", 1, dcyc);

    send_byte(8'h40, 1);
    send_byte(8'h00, 3);
    send_byte(8'h04, 0);
    send_byte(8'h00, 2);
    send_word(16'h0102, 8'h40, 2, 0);
    send_word(16'h0304, 8'h41, 0, 5);
    send_word(16'hA5A5, 8'h42, 3, 1);
    send_word(16'hFFFF, 8'h43, 5, 4);
    finish_frame("stall", 1, last_acc);

    send_header(16'h0020, 16'd3);
    send_word(16'h1111, 8'h20, 0, 0);
    send_byte(8'h22, 0);
    @(negedge clk);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    #1;
    check("abort_ready_kept", in_ready, 1);
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_wr", wr, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    finish_frame("abort", 0, 0);
    single_word("post_abort", 8'h30, 16'hBEEF);

    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("midrst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    check("midrst_waddr", waddr, 0);
    check("midrst_wdata", wdata, 0);
    check("midrst_wr", wr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready_back", in_ready, 1);
    wr_q.delete();
    done_q.delete();
    single_word("post_rst", 8'h10, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
